// File: rtl/pll_reset_sequencer_if.sv
// Lock input, soft request and staged reset outputs of pll_reset_sequencer.
// RSTSEQ_LOSS_CNT_EN adds the lock_loss_cnt signal.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       soft_rst_req;
    logic       sys_rst_n;
    logic       periph_rst_n;
    logic       ready;
`ifdef RSTSEQ_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;

    modport master (
        output pll_locked, soft_rst_req,
        input  sys_rst_n, periph_rst_n, ready, lock_loss_cnt
    );
    modport slave (
        input  pll_locked, soft_rst_req,
        output sys_rst_n, periph_rst_n, ready, lock_loss_cnt
    );
`else
    modport master (
        output pll_locked, soft_rst_req,
        input  sys_rst_n, periph_rst_n, ready
    );
    modport slave (
        input  pll_locked, soft_rst_req,
        output sys_rst_n, periph_rst_n, ready
    );
`endif
endinterface

// File: rtl/pll_reset_sequencer.sv
// Staged reset release after PLL lock: sys reset first, periph reset after a gap.
// Optional RSTSEQ_LOSS_CNT_EN adds a saturating lock-loss event counter.
module pll_reset_sequencer #(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_GAP_CYCLES   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pll_reset_sequencer_if.slave  bus
);
    localparam int unsigned CNT_MAX = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                                      LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABLE,
        REL_SYS,
        RUN
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   abort;
    state_t                 state;
    state_t                 next_state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic                   sys_q;
    logic                   periph_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];
    assign abort    = !locked_s || bus.soft_rst_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // cnt_next stays 0 on every transition, so each state starts counting from zero
    always_comb begin
        next_state = state;
        cnt_next   = '0;
        case (state)
            WAIT_LOCK: begin
                if (locked_s && !bus.soft_rst_req) next_state = STABLE;
            end
            STABLE: begin
                if (abort)
                    next_state = WAIT_LOCK;
                else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1))
                    next_state = REL_SYS;
                else
                    cnt_next = cnt + 1'b1;
            end
            REL_SYS: begin
                if (abort)
                    next_state = WAIT_LOCK;
                else if (cnt == CNT_W'(STAGE_GAP_CYCLES - 1))
                    next_state = RUN;
                else
                    cnt_next = cnt + 1'b1;
            end
            RUN: begin
                if (abort) next_state = WAIT_LOCK;
            end
            default: next_state = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_q    <= 1'b0;
            periph_q <= 1'b0;
        end else begin
            sys_q    <= (next_state == REL_SYS) || (next_state == RUN);
            periph_q <= (next_state == RUN);
        end
    end

    assign bus.sys_rst_n    = sys_q;
    assign bus.periph_rst_n = periph_q;
    assign bus.ready        = periph_q;

`ifdef RSTSEQ_LOSS_CNT_EN
    logic [7:0] loss_q;
    logic       loss_evt;

    // Only lock loss out of a released state counts; soft-only exits do not
    assign loss_evt = ((state == REL_SYS) || (state == RUN)) && !locked_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (loss_evt && (loss_q != '1)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign bus.lock_loss_cnt = loss_q;
`endif
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: a run-length reference model predicts every cycle.
// Lock-loss counter checks are active when RSTSEQ_LOSS_CNT_EN is defined.
module tb_pll_reset_sequencer;
    localparam int S = 2;
    localparam int L = 8;
    localparam int G = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pll_reset_sequencer_if bus ();

    pll_reset_sequencer #(
        .SYNC_STAGES        (S),
        .LOCK_STABLE_CYCLES (L),
        .STAGE_GAP_CYCLES   (G)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       sys;
        logic       per;
        logic       rdy;
        logic [7:0] cnt;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a released state is just a run of consecutive "good" edges,
    // where good = lock seen S edges ago and no soft request now.
    bit m_lk[$];
    int run      = 0;
    int m_loss   = 0;
    bit rst_seen = 1'b1;

    always @(negedge rst_n) rst_seen = 1'b1;

    initial begin
        exp_t e;
        bit   ls;
        forever begin
            @(posedge clk);
            if (rst_seen || !rst_n) begin
                m_lk.delete();
                run      = 0;
                m_loss   = 0;
                rst_seen = 1'b0;
            end
            if (rst_n) begin
                ls = (m_lk.size() >= S) ? m_lk[m_lk.size() - S] : 1'b0;
                m_lk.push_back(bus.pll_locked);
                if (m_lk.size() > S) void'(m_lk.pop_front());
                if (ls && !bus.soft_rst_req) begin
                    if (run < 100000) run++;
                end else begin
                    if (run > L && !ls && m_loss < 255) m_loss++;
                    run = 0;
                end
            end
            e.sys = (run > L);
            e.per = (run > L + G);
            e.rdy = e.per;
            e.cnt = 8'(m_loss);
            expq.push_back(e);
        end
    end

    initial begin
        exp_t r;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty: got 0 entries expected 1 at t=%0t", $time);
            end else begin
                r = expq.pop_front();
                check("sb_sys_rst_n", bus.sys_rst_n, r.sys);
                check("sb_periph_rst_n", bus.periph_rst_n, r.per);
                check("sb_ready", bus.ready, r.rdy);
`ifdef RSTSEQ_LOSS_CNT_EN
                check("sb_lock_loss_cnt", bus.lock_loss_cnt, r.cnt);
`endif
            end
        end
    end

    // Edge index (1-based) of the first rise of sys and of periph&ready within maxe edges
    task automatic measure(input int maxe, output int se, output int pe);
        se = 0;
        pe = 0;
        for (int e = 1; e <= maxe; e++) begin
            @(posedge clk);
            #1;
            if (bus.sys_rst_n === 1'b1 && se == 0) se = e;
            if (bus.periph_rst_n === 1'b1 && bus.ready === 1'b1 && pe == 0) pe = e;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int se;
        int pe;
        int lo;
        int hold;

        bus.pll_locked   = 1'b0;
        bus.soft_rst_req = 1'b0;
        rst_n            = 1'b0;

        // Power-up
        repeat (3) @(negedge clk);
        check("rst_sys", bus.sys_rst_n, 0);
        check("rst_periph", bus.periph_rst_n, 0);
        check("rst_ready", bus.ready, 0);
        rst_n          = 1'b1;
        bus.pll_locked = 1'b1;
        measure(20, se, pe);
        check("pwrup_sys_edge", se, S + L + 1);
        check("pwrup_per_edge", pe, S + L + 1 + G);

        // Lock loss in RUN, then re-lock
        @(negedge clk);
        bus.pll_locked = 1'b0;
        lo = 0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            if (lo == 0 && bus.sys_rst_n === 1'b0 && bus.periph_rst_n === 1'b0 && bus.ready === 1'b0)
                lo = e;
        end
        check("loss_edge", lo, S + 1);
`ifdef RSTSEQ_LOSS_CNT_EN
        check("loss_cnt_one", bus.lock_loss_cnt, 1);
`endif
        @(negedge clk);
        bus.pll_locked = 1'b1;
        measure(20, se, pe);
        check("relock_sys_edge", se, 11);
        check("relock_per_edge", pe, 15);

        // One-cycle soft request while locked
        @(negedge clk);
        bus.soft_rst_req = 1'b1;
        @(posedge clk);
        #1;
        check("soft_sys_next", bus.sys_rst_n, 0);
        check("soft_per_next", bus.periph_rst_n, 0);
        check("soft_rdy_next", bus.ready, 0);
        @(negedge clk);
        bus.soft_rst_req = 1'b0;
        measure(20, se, pe);
        check("soft_sys_edge", se, L + 1);
        check("soft_per_edge", pe, L + 1 + G);
`ifdef RSTSEQ_LOSS_CNT_EN
        check("soft_cnt_unchanged", bus.lock_loss_cnt, 1);
`endif

        // Lock glitch of 2 cycles at STABLE cnt=5
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        bus.pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        bus.pll_locked = 1'b1;
        measure(20, se, pe);
        check("glitch_sys_edge", se, 11);
        check("glitch_per_edge", pe, 15);

        // Async reset pulse in REL_SYS
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        check("relsys_sys_pre", bus.sys_rst_n, 1);
        check("relsys_per_pre", bus.periph_rst_n, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_sys", bus.sys_rst_n, 0);
        check("async_per", bus.periph_rst_n, 0);
        check("async_rdy", bus.ready, 0);
        #1;
        rst_n = 1'b1;
        measure(20, se, pe);
        check("async_rerun_sys", se, 11);
        check("async_rerun_per", pe, 15);

        // Randomized lock / soft-request traffic, checked by the scoreboard
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            bus.pll_locked   = ($urandom_range(0, 3) != 0);
            bus.soft_rst_req = ($urandom_range(0, 9) == 0);
            hold             = $urandom_range(1, 25);
            @(negedge clk);
            bus.soft_rst_req = 1'b0;
            repeat (hold) @(negedge clk);
        end

`ifdef RSTSEQ_LOSS_CNT_EN
        // Saturation: each event reaches REL_SYS or RUN before losing lock
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            bus.pll_locked = 1'b1;
            repeat (S + L + 4) @(negedge clk);
            bus.pll_locked = 1'b0;
            repeat (4) @(negedge clk);
        end
        check("sat_cnt", bus.lock_loss_cnt, 255);
        bus.pll_locked = 1'b1;
        repeat (S + L + 4) @(negedge clk);
        bus.pll_locked = 1'b0;
        repeat (4) @(negedge clk);
        check("sat_hold", bus.lock_loss_cnt, 255);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
